core_reg_tracer: RTL and testbench

Passive trace monitor attached to the `core` register outputs (`regA`, `regB`, `regO`). On every cycle where the enabled snapshot differs from the last captured one, it records the snapshot into a small FIFO. It then serializes each snapshot off-chip as a two-byte UART (8N1) frame. It is the read-out end of the core's register interface and lets the lab bench and hardware observe core execution without a debugger.

---
 rtl/core_reg_tracer.sv | 189 ++++++++++++++++++
 tb/tb_core_reg_tracer.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/core_reg_tracer.sv
// core_reg_tracer: passive trace monitor for the core register outputs.
// Captures {regA, regB, regO} whenever the enabled snapshot changes, queues it
// in a small FIFO and sends each entry as a two-byte UART 8N1 frame:
// byte0 = {regA, regB}, byte1 = {4'hC, regO}.
//
// Ports:
//   clk          - clock, rising edge
//   resetn       - asynchronous active-low reset
//   regA/B/O     - core registers being traced (4 bits each)
//   enable       - capture enable (transmission of queued entries continues)
//   tx           - UART line, idle high, registered
//   busy         - TX FSM not idle or FIFO non-empty
//   overflow     - sticky, a snapshot was dropped on a full FIFO
//   frame_count  - completed frames, modulo 256
module core_reg_tracer #(
  parameter int unsigned CLKS_PER_BIT = 4,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [3:0] regA,
  input  logic [3:0] regB,
  input  logic [3:0] regO,
  input  logic       enable,
  output logic       tx,
  output logic       busy,
  output logic       overflow,
  output logic [7:0] frame_count
);

  localparam int unsigned PtrW  = $clog2(FIFO_DEPTH);
  localparam int unsigned CntFW = PtrW + 1;
  localparam int unsigned CntW  = $clog2(CLKS_PER_BIT);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  state_e            state_q, state_d;
  logic              byte_sel_q, byte_sel_d;
  logic [2:0]        bit_idx_q, bit_idx_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [11:0]       frame_q, frame_d;
  logic              tx_q, tx_d;
  logic [7:0]        fcount_q, fcount_d;

  logic [11:0]       last_q;
  logic              primed_q;
  logic              overflow_q;

  logic [11:0]       mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CntFW-1:0]  count_q;

  logic [11:0]       snap;
  logic              capture, fifo_empty, fifo_full, push, pop;
  logic              bit_end;
  logic [7:0]        cur_byte;
  logic [2:0]        bit_nxt;

  assign snap       = {regA, regB, regO};
  assign capture    = enable && (!primed_q || (snap != last_q));
  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CntFW'(FIFO_DEPTH));
  assign pop        = (state_q == StIdle) && !fifo_empty;
  // A pop on the same edge frees a slot, so a full FIFO can still accept.
  assign push       = capture && (!fifo_full || pop);

  assign bit_end  = (cnt_q == CntW'(CLKS_PER_BIT - 1));
  assign cur_byte = byte_sel_q ? {4'hC, frame_q[3:0]} : frame_q[11:4];
  assign bit_nxt  = bit_idx_q + 3'd1;

  // Capture tracking; last updates even on a dropped push so it is never re-sent.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      last_q     <= '0;
      primed_q   <= 1'b0;
      overflow_q <= 1'b0;
    end else if (capture) begin
      last_q   <= snap;
      primed_q <= 1'b1;
      if (!push) overflow_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= snap;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      if (push && !pop)      count_q <= count_q + CntFW'(1);
      else if (pop && !push) count_q <= count_q - CntFW'(1);
    end
  end

  always_comb begin
    state_d    = state_q;
    byte_sel_d = byte_sel_q;
    bit_idx_d  = bit_idx_q;
    cnt_d      = cnt_q;
    frame_d    = frame_q;
    tx_d       = tx_q;
    fcount_d   = fcount_q;
    unique case (state_q)
      StIdle: begin
        tx_d = 1'b1;
        if (!fifo_empty) begin
          frame_d    = mem_q[rd_ptr_q];
          byte_sel_d = 1'b0;
          cnt_d      = '0;
          tx_d       = 1'b0;
          state_d    = StStart;
        end
      end
      StStart: begin
        if (bit_end) begin
          cnt_d     = '0;
          bit_idx_d = 3'd0;
          tx_d      = cur_byte[0];
          state_d   = StData;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StData: begin
        if (bit_end) begin
          cnt_d = '0;
          if (bit_idx_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = StStop;
          end else begin
            bit_idx_d = bit_nxt;
            tx_d      = cur_byte[bit_nxt];
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StStop: begin
        if (bit_end) begin
          cnt_d = '0;
          if (!byte_sel_q) begin
            // byte1 follows byte0 with no idle gap
            byte_sel_d = 1'b1;
            tx_d       = 1'b0;
            state_d    = StStart;
          end else begin
            fcount_d = fcount_q + 8'd1;
            state_d  = StIdle;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= StIdle;
      byte_sel_q <= 1'b0;
      bit_idx_q  <= 3'd0;
      cnt_q      <= '0;
      frame_q    <= '0;
      tx_q       <= 1'b1;
      fcount_q   <= 8'd0;
    end else begin
      state_q    <= state_d;
      byte_sel_q <= byte_sel_d;
      bit_idx_q  <= bit_idx_d;
      cnt_q      <= cnt_d;
      frame_q    <= frame_d;
      tx_q       <= tx_d;
      fcount_q   <= fcount_d;
    end
  end

  assign tx          = tx_q;
  assign busy        = (state_q != StIdle) || !fifo_empty;
  assign overflow    = overflow_q;
  assign frame_count = fcount_q;

endmodule

// File: tb/tb_core_reg_tracer.sv
// Directed self-checking bench for core_reg_tracer (CLKS_PER_BIT=4, FIFO_DEPTH=4).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_core_reg_tracer;

  localparam int C = 4;

  logic       clk;
  logic       resetn;
  logic [3:0] regA, regB, regO;
  logic       enable;
  logic       tx, busy, overflow;
  logic [7:0] frame_count;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] rb0 [5];
  logic [7:0] rb1 [5];
  logic       rok [5];

  core_reg_tracer #(.CLKS_PER_BIT(C), .FIFO_DEPTH(4)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .regA       (regA),
    .regB       (regB),
    .regO       (regO),
    .enable     (enable),
    .tx         (tx),
    .busy       (busy),
    .overflow   (overflow),
    .frame_count(frame_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] want);
    n_checks++;
    assert (obs === want)
    else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  // Waits (bounded) for a start bit, then samples each bit on its first cycle.
  task automatic recv_frame(output logic [7:0] b0, output logic [7:0] b1, output logic ok);
    int         waited;
    logic [7:0] d;
    waited = 0;
    ok = 1'b1;
    b0 = 8'h00;
    b1 = 8'h00;
    while (tx !== 1'b0 && waited < 400) begin
      @(negedge clk);
      waited++;
    end
    if (tx !== 1'b0) begin
      ok = 1'b0;
      return;
    end
    for (int by = 0; by < 2; by++) begin
      if (tx !== 1'b0) ok = 1'b0;
      for (int i = 0; i < 8; i++) begin
        repeat (C) @(negedge clk);
        d[i] = tx;
      end
      repeat (C) @(negedge clk);
      if (tx !== 1'b1) ok = 1'b0;
      if (by == 0) begin
        b0 = d;
        repeat (C) @(negedge clk);
      end else begin
        b1 = d;
      end
    end
  endtask

  task automatic count_lows(input int cycles, output int lows, output int busys);
    lows = 0;
    busys = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
      if (busy !== 1'b0) busys++;
    end
  endtask

  initial begin
    logic [7:0] b0, b1;
    logic       ok;
    int         lows, busys, w;

    resetn = 1'b0;
    regA = 4'd3; regB = 4'd5; regO = 4'd8;
    enable = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_tx", 16'(tx), 16'd1);
    chk("rst_busy", 16'(busy), 16'd0);
    chk("rst_ovf", 16'(overflow), 16'd0);
    chk("rst_fc", 16'(frame_count), 16'd0);

    // 1: single frame from the first enabled cycle after reset
    resetn = 1'b1;
    @(negedge clk);
    chk("t1_tx_cap", 16'(tx), 16'd1);
    chk("t1_busy_cap", 16'(busy), 16'd1);
    @(negedge clk);
    chk("t1_tx_start", 16'(tx), 16'd0);
    recv_frame(b0, b1, ok);
    chk("t1_ok", 16'(ok), 16'd1);
    chk("t1_b0", 16'(b0), 16'h35);
    chk("t1_b1", 16'(b1), 16'hC8);
    repeat (C) @(negedge clk);
    chk("t1_fc", 16'(frame_count), 16'd1);
    chk("t1_busy_end", 16'(busy), 16'd0);
    count_lows(100, lows, busys);
    chk("t1_no_more", 16'(lows), 16'd0);

    // 2: regO change, one-cycle latency to start bit
    regO = 4'd9;
    @(negedge clk);
    chk("t2_tx_cap", 16'(tx), 16'd1);
    @(negedge clk);
    chk("t2_tx_start", 16'(tx), 16'd0);
    recv_frame(b0, b1, ok);
    chk("t2_ok", 16'(ok), 16'd1);
    chk("t2_b0", 16'(b0), 16'h35);
    chk("t2_b1", 16'(b1), 16'hC9);
    repeat (C) @(negedge clk);
    chk("t2_fc", 16'(frame_count), 16'd2);

    // 3: six snapshots on consecutive edges, sixth dropped
    fork
      begin
        regA = 4'h1; regB = 4'h2; regO = 4'h3; @(negedge clk);
        regA = 4'h4; regB = 4'h5; regO = 4'h6; @(negedge clk);
        regA = 4'h7; regB = 4'h8; regO = 4'h9; @(negedge clk);
        regA = 4'hA; regB = 4'hB; regO = 4'hC; @(negedge clk);
        regA = 4'hD; regB = 4'hE; regO = 4'hF; @(negedge clk);
        chk("t3_ovf_pre", 16'(overflow), 16'd0);
        regA = 4'h0; regB = 4'h1; regO = 4'h2; @(negedge clk);
        chk("t3_ovf", 16'(overflow), 16'd1);
      end
      begin
        for (int f = 0; f < 5; f++) recv_frame(rb0[f], rb1[f], rok[f]);
      end
    join
    chk("t3_ok0", 16'(rok[0]), 16'd1);
    chk("t3_b0_0", 16'(rb0[0]), 16'h12);
    chk("t3_b1_0", 16'(rb1[0]), 16'hC3);
    chk("t3_b0_1", 16'(rb0[1]), 16'h45);
    chk("t3_b1_1", 16'(rb1[1]), 16'hC6);
    chk("t3_b0_2", 16'(rb0[2]), 16'h78);
    chk("t3_b1_2", 16'(rb1[2]), 16'hC9);
    chk("t3_b0_3", 16'(rb0[3]), 16'hAB);
    chk("t3_b1_3", 16'(rb1[3]), 16'hCC);
    chk("t3_ok4", 16'(rok[4]), 16'd1);
    chk("t3_b0_4", 16'(rb0[4]), 16'hDE);
    chk("t3_b1_4", 16'(rb1[4]), 16'hCF);
    repeat (C) @(negedge clk);
    chk("t3_fc", 16'(frame_count), 16'd7);
    chk("t3_busy", 16'(busy), 16'd0);
    count_lows(100, lows, busys);
    chk("t3_no_sixth", 16'(lows), 16'd0);

    // 4: enable low while registers toggle
    enable = 1'b0;
    lows = 0;
    busys = 0;
    for (int i = 0; i < 50; i++) begin
      regA = 4'($urandom); regB = 4'($urandom); regO = 4'($urandom);
      @(negedge clk);
      if (tx !== 1'b1) lows++;
      if (busy !== 1'b0) busys++;
    end
    chk("t4_dis_tx", 16'(lows), 16'd0);
    chk("t4_dis_busy", 16'(busys), 16'd0);
    regA = 4'h0; regB = 4'h1; regO = 4'h2;
    @(negedge clk);
    enable = 1'b1;
    count_lows(60, lows, busys);
    chk("t4_same_tx", 16'(lows), 16'd0);
    regA = 4'h6;
    recv_frame(b0, b1, ok);
    chk("t4_ok", 16'(ok), 16'd1);
    chk("t4_b0", 16'(b0), 16'h61);
    chk("t4_b1", 16'(b1), 16'hC2);
    repeat (C) @(negedge clk);
    chk("t4_fc", 16'(frame_count), 16'd8);

    // 5: short reset pulse during byte0 data bits
    regB = 4'h9;
    w = 0;
    while (tx !== 1'b0 && w < 50) begin
      @(negedge clk);
      w++;
    end
    chk("t5_started", 16'(tx), 16'd0);
    repeat (2 * C + 2) @(negedge clk);
    @(posedge clk);
    #1 resetn = 1'b0;
    #2;
    chk("t5_rst_tx", 16'(tx), 16'd1);
    chk("t5_rst_fc", 16'(frame_count), 16'd0);
    chk("t5_rst_ovf", 16'(overflow), 16'd0);
    chk("t5_rst_busy", 16'(busy), 16'd0);
    #1 resetn = 1'b1;
    recv_frame(b0, b1, ok);
    chk("t5_ok", 16'(ok), 16'd1);
    chk("t5_b0", 16'(b0), 16'h69);
    chk("t5_b1", 16'(b1), 16'hC2);
    repeat (C) @(negedge clk);
    chk("t5_fc", 16'(frame_count), 16'd1);

    // 6: 256 frames, changes spaced 81 cycles, count wraps
    @(negedge clk);
    resetn = 1'b0;
    regA = 4'd3;
    @(negedge clk);
    resetn = 1'b1;
    for (int i = 1; i < 256; i++) begin
      repeat (81) @(negedge clk);
      regA = (i % 2 == 1) ? 4'd4 : 4'd3;
      if (i == 255) chk("t6_fc_254", 16'(frame_count), 16'd254);
    end
    repeat (90) @(negedge clk);
    chk("t6_fc_wrap", 16'(frame_count), 16'd0);
    chk("t6_ovf", 16'(overflow), 16'd0);
    chk("t6_busy", 16'(busy), 16'd0);
    chk("t6_tx", 16'(tx), 16'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
